// File: rtl/alu.sv
// rtl/alu.sv - registered 8-op ALU with zero flag and optional signed-overflow flag (ALU_OVERFLOW_EN)
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ctrl,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow
);

    // ctrl[2] selects inverted B and supplies the carry-in, so 110 and 111 both see A - B
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic             slt;
    logic [WIDTH-1:0] result;
    logic             ovf_next;

    // shared adder; the carry-out is simply not kept, so the result wraps
    always_comb begin
        b_eff   = ctrl[2] ? ~B : B;
        sum     = A + b_eff + {{(WIDTH-1){1'b0}}, ctrl[2]};
        // signed overflow: both addend signs agree but the sum sign differs
        add_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        // sign of A - B corrected by overflow gives a true signed less-than
        slt     = sum[WIDTH-1] ^ add_ovf;
    end

    // operation select; logical ops never touch the adder path
    always_comb begin
        result = '0;
        case (ctrl)
            3'b000:  result = A & B;
            3'b001:  result = A | B;
            3'b010:  result = sum;
            3'b011:  result = A ^ B;
            3'b100:  result = A & ~B;
            3'b101:  result = A | ~B;
            3'b110:  result = sum;
            3'b111:  result = {{(WIDTH-1){1'b0}}, slt};
            default: result = '0;
        endcase
        // only add (010) and sub (110) report overflow; SLT does not
        ovf_next = (ctrl[1:0] == 2'b10) ? add_ovf : 1'b0;
    end

    // result and zero flag registered together so zero always tracks out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out  <= '0;
            zero <= 1'b1;
        end else begin
            out  <= result;
            zero <= (result == '0);
        end
    end

`ifdef ALU_OVERFLOW_EN
    // registered signed-overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= ovf_next;
        end
    end
`else
    // overflow reporting compiled out; port kept for a stable interface
    assign overflow = 1'b0;

    logic unused_ovf;
    assign unused_ovf = ovf_next;
`endif

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu with directed and random vectors against a signed-arithmetic model
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ctrl;
    logic [31:0] out;
    logic        zero;
    logic        overflow;

    int total = 0;
    int bad   = 0;

`ifdef ALU_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .ctrl     (ctrl),
        .out      (out),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                                  output logic [31:0] r, output logic o);
        longint sa;
        longint sb;
        longint s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        o  = 1'b0;
        r  = '0;
        case (c)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                s = sa + sb;
                r = s[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd3: r = a ^ b;
            3'd4: r = a & ~b;
            3'd5: r = a | ~b;
            3'd6: begin
                s = sa - sb;
                r = s[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        o = o & OVF_EN;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive away from the edge, clock once, then compare all outputs against the model
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        logic [31:0] er;
        logic        eo;
        @(negedge clk);
        A = a;
        B = b;
        ctrl = c;
        model(a, b, c, er, eo);
        @(posedge clk);
        #1;
        chk({tag, ".out"}, out, er);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    initial begin
        reset = 1'b1;
        A = '0;
        B = '0;
        ctrl = 3'b000;
        #12;
        chk("rst.out", out, 32'h0);
        chk("rst.zero", {31'd0, zero}, 32'd1);
        chk("rst.ovf", {31'd0, overflow}, 32'd0);

        // release between edges; the next edge holds the first result
        @(negedge clk);
        reset = 1'b0;
        step("add1", 32'h00000000, 32'h00000001, 3'b010);
        chk("add1.lit", out, 32'h00000001);
        step("subeq", 32'h12345678, 32'h12345678, 3'b110);
        chk("subeq.zero.lit", {31'd0, zero}, 32'd1);
        step("slt_neg", 32'hFFFFFFFF, 32'h00000001, 3'b111);
        chk("slt_neg.lit", out, 32'h00000001);
        step("slt_swap", 32'h00000001, 32'hFFFFFFFF, 3'b111);
        chk("slt_swap.lit", out, 32'h00000000);
        step("addovf", 32'h7FFFFFFF, 32'h00000001, 3'b010);
        chk("addovf.lit", out, 32'h80000000);
        chk("addovf.flag", {31'd0, overflow}, {31'd0, OVF_EN});
        step("subwrap", 32'h80000000, 32'h00000001, 3'b110);
        chk("subwrap.lit", out, 32'h7FFFFFFF);
        step("slt_wrap", 32'h80000000, 32'h00000001, 3'b111);
        chk("slt_wrap.lit", out, 32'h00000001);
        step("slt_ovf2", 32'h7FFFFFFF, 32'h80000000, 3'b111);

        // logical ops with fixed pattern
        step("and", 32'hF0F0F0F0, 32'hFF00FF00, 3'b000);
        chk("and.lit", out, 32'hF000F000);
        step("or", 32'hF0F0F0F0, 32'hFF00FF00, 3'b001);
        chk("or.lit", out, 32'hFFF0FFF0);
        step("xor", 32'hF0F0F0F0, 32'hFF00FF00, 3'b011);
        chk("xor.lit", out, 32'h0FF00FF0);
        step("andn", 32'hF0F0F0F0, 32'hFF00FF00, 3'b100);
        chk("andn.lit", out, 32'h00F000F0);
        step("orn", 32'hF0F0F0F0, 32'hFF00FF00, 3'b101);
        chk("orn.lit", out, 32'hF0FFF0FF);

        // async reset between edges after a nonzero overflowing result
        step("pre_rst", 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010);
        #3;
        reset = 1'b1;
        #1;
        chk("arst.out", out, 32'h0);
        chk("arst.zero", {31'd0, zero}, 32'd1);
        chk("arst.ovf", {31'd0, overflow}, 32'd0);
        // pending inputs while in reset are discarded
        A = 32'h00000005;
        B = 32'h00000003;
        ctrl = 3'b010;
        @(posedge clk);
        #1;
        chk("hold.out", out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", 32'h00000005, 32'h00000003, 3'b110);
        chk("post_rst.lit", out, 32'h00000002);

        // random vectors, biased toward sign-boundary operands
        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = {ra[31], {31{ra[30]}}};
            if ($urandom_range(0, 3) == 0) rb = ra;
            step("rand", ra, rb, 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 A  input  WIDTH  operand A.
REQ-005 B  input  WIDTH  operand B.
REQ-006 ctrl  input  3  operation select.
REQ-007 out  output  WIDTH  registered result.
REQ-008 zero  output  1  registered flag, 1 when the registered out equals 0.
REQ-009 overflow  output  1  registered signed-overflow flag for add/sub.
REQ-010 Single clock domain: clk only; reset asynchronous, active-high.

Function
REQ-011 The ctrl encoding SHALL be as follows:
- 000: A AND B.
- 001: A OR B.
- 010: A + B.
- 011: A XOR B.
- 100: A AND NOT B.
- 101: A OR NOT B.
- 110: A - B.
- 111: SLT.
REQ-012 Add/sub SHALL use a single WIDTH-bit adder computing A + (B or ~B) + carry-in, with carry-in = ctrl[2] for ops 010/110; carry-out is discarded and the result wraps modulo 2^WIDTH.
REQ-013 SLT SHALL be a signed comparison: out = 1 (zero-extended) when A < B in two's complement, else 0. The comparison is derived from the sign of A - B XOR the subtraction overflow, so it is correct across overflow.
REQ-014 Logical ops SHALL be purely bitwise with no carry effects.
REQ-015 Latency SHALL be 1 cycle: A, B and ctrl are sampled at a rising clk edge, and out, zero and overflow update at that same edge.
REQ-016 Inputs SHALL be sampled every cycle with no handshake or stall.
REQ-017 zero SHALL be computed from the same-cycle result and registered alongside out, so zero == (out == 0) always.
REQ-018 overflow SHALL be 1 only for ctrl 010/110 when the operand signs make the signed result unrepresentable.
REQ-019 overflow SHALL be 0 for all other ctrl values, including SLT.
REQ-020 Unsigned carry/borrow SHALL NOT be reported.

Reset
REQ-021 While reset = 1, out = 0, zero = 1 and overflow = 0, asynchronously and independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard the pending result.
REQ-023 The first result after reset deasserts SHALL be the one captured at the first rising clk edge with reset = 0.

Configuration
REQ-024 Macro ALU_OVERFLOW_EN SHALL control the overflow detection logic.
REQ-025 With ALU_OVERFLOW_EN defined: overflow detection is compiled in and behaves per REQ-018 and REQ-019.
REQ-026 Without ALU_OVERFLOW_EN: the overflow port remains present but is tied to constant 0, and no overflow register is instantiated. SLT still uses internal overflow correction, so out and zero are identical in both builds.

Verification
REQ-027 Bench SHALL cover:
- Add: A=0x00000000, B=0x00000001, ctrl=010, one clk -> out=0x00000001, zero=0, overflow=0.
- Equal subtract: A=0x12345678, B=0x12345678, ctrl=110 -> out=0x00000000, zero=1.
- Signed SLT: A=0xFFFFFFFF, B=0x00000001, ctrl=111 -> out=0x00000001. Swapped operands -> out=0x00000000.
- Overflow: A=0x7FFFFFFF, B=0x00000001, ctrl=010 -> out=0x80000000, overflow=1 (0 when ALU_OVERFLOW_EN undefined).
- Wrap: A=0x80000000, B=0x00000001, ctrl=110 -> out=0x7FFFFFFF, overflow=1. Then ctrl=111 -> out=1.
- Async reset: assert reset between clk edges after a nonzero result -> out=0, zero=1, overflow=0 immediately. Logical ops 000/001/011/100/101 with A=0xF0F0F0F0, B=0xFF00FF00 -> out=0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x00F000F0, 0xF0FFF0FF.
